if_id_queue: RTL and testbench

Instruction queue between the fetch stage and the decode stage of the rv32 core. It buffers fetched instruction/PC pairs in a small circular FIFO, so a decode stall does not immediately stall fetch. It also discards all buffered instructions when a taken branch redirects fetch. Fetch pushes through a valid/ready handshake and decode pops through a valid/ready handshake.

---
 rtl/if_id_queue_if.sv | 22 ++
 rtl/if_id_queue.sv | 66 ++++++
 tb/tb_if_id_queue.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle: the push side (in_*) and the pop side (out_*).
// The queue connects through "slave" and its neighbours through "master".
interface if_id_queue_if;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc
    );
endinterface

// File: rtl/if_id_queue.sv
// Circular instruction/PC FIFO between fetch and decode.
// A taken-branch flush discards every buffered entry on the next clock edge.
module if_id_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    if_id_queue_if.slave               bus,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // in_ready depends only on count, so out_ready never reaches it combinationally.
    assign bus.in_ready  = (count != CNT_FULL);
    assign bus.out_valid = (count != '0);
    assign bus.out_instr = bus.out_valid ? instr_mem[rd_ptr] : NOP_INSTR;
    assign bus.out_pc    = bus.out_valid ? pc_mem[rd_ptr] : 32'h0;

    assign push = bus.in_valid && bus.in_ready && !flush;
    assign pop  = bus.out_valid && bus.out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; out_valid masks any stale entry.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= bus.in_instr;
            pc_mem[wr_ptr]    <= bus.in_pc;
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_if_id_queue;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic clk;
    logic rst_n;
    logic flush;
    logic [$clog2(DEPTH+1)-1:0] count;

    if_id_queue_if bus ();

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus),
        .count (count)
    );

    int   checks = 0;
    int   errors = 0;
    ent_t model_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        int n;
        n = model_q.size();
        chk({tag, ":count"}, 32'(count), 32'(n));
        chk({tag, ":in_ready"}, 32'(bus.in_ready), 32'(n < DEPTH));
        chk({tag, ":out_valid"}, 32'(bus.out_valid), 32'(n > 0));
        chk({tag, ":out_instr"}, bus.out_instr, (n > 0) ? model_q[0].instr : NOP);
        chk({tag, ":out_pc"}, bus.out_pc, (n > 0) ? model_q[0].pc : 32'h0);
    endtask

    // One clock cycle: drive, check current state before the edge, then advance the model.
    task automatic cycle(input string tag, input logic iv, input logic [31:0] ins,
                         input logic [31:0] pc, input logic ordy, input logic fl);
        bit do_push;
        bit do_pop;
        ent_t e;
        bus.in_valid  = iv;
        bus.in_instr  = ins;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        flush         = fl;
        @(negedge clk);
        check_outputs(tag);
        do_push = iv && (model_q.size() < DEPTH);
        do_pop  = ordy && (model_q.size() > 0);
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                e.pc    = pc;
                e.instr = ins;
                model_q.push_back(e);
            end
        end
        #1;
    endtask

    initial begin
        logic [31:0] fill_instr [4];
        fill_instr[0] = 32'h0050_0093;
        fill_instr[1] = 32'h0010_0113;
        fill_instr[2] = 32'h0020_81B3;
        fill_instr[3] = 32'h0031_8233;

        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'hCAFE_0001;
        bus.in_pc     = 32'h100;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_outputs("reset");
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++)
            cycle("fill", 1'b1, fill_instr[i], 32'(4 * i), 1'b0, 1'b0);
        cycle("full_reject", 1'b1, 32'hDEAD_BEEF, 32'h10, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            cycle("drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle("drained", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        cycle("pp_pre", 1'b1, 32'h1111_0001, 32'h200, 1'b0, 1'b0);
        cycle("pp_pre", 1'b1, 32'h1111_0002, 32'h204, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++)
            cycle("push_pop", 1'b1, 32'h2222_0000 + 32'(i), 32'h300 + 32'(4 * i), 1'b1, 1'b0);

        cycle("flush_pre", 1'b1, 32'h3333_0001, 32'h400, 1'b0, 1'b0);
        cycle("flush_at3", 1'b1, 32'hBAD0_0BAD, 32'h404, 1'b0, 1'b1);
        cycle("post_flush", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        cycle("empty_push", 1'b1, 32'h4444_0001, 32'h500, 1'b1, 1'b0);
        cycle("empty_pop", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle("empty_after", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        cycle("arst_pre", 1'b1, 32'h5555_0001, 32'h600, 1'b0, 1'b0);
        cycle("arst_pre", 1'b1, 32'h5555_0002, 32'h604, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        #1;
        chk("arst_before:count", 32'(count), 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        chk("arst:out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst:count", 32'(count), 32'd0);
        @(negedge clk);
        check_outputs("arst_hold");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 400; i++)
            cycle("random", ($urandom_range(0, 9) < 7), $urandom, $urandom,
                  $urandom_range(0, 1) == 1, ($urandom_range(0, 19) == 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
